// File: rtl/ysyx_22041207_mdu_pkg.sv
// Shared encodings, widths and FSM state type for the MDU multiply controller.
package ysyx_22041207_mdu_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    localparam logic [1:0] MDU_OP_MUL  = 2'd0;
    localparam logic [1:0] MDU_OP_MULW = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } mdu_state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22041207_mdu_opprep.sv
// Combinational operand preparation: MULW sign-extension, reserved-op and zero detect.
// Zero detect is only live when YSYX_22041207_MDU_ZERO_BYPASS_EN is defined.
module ysyx_22041207_mdu_opprep
    import ysyx_22041207_mdu_pkg::*;
(
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic [XLEN-1:0] opa,
    output logic [XLEN-1:0] opb,
    output logic            rsvd,
    output logic            zero_skip
);

    always_comb begin
        opa = src1;
        opb = src2;
        if (op == MDU_OP_MULW) begin
            opa = sext32(src1[31:0]);
            opb = sext32(src2[31:0]);
        end
    end

    assign rsvd = (op != MDU_OP_MUL) && (op != MDU_OP_MULW);

`ifdef YSYX_22041207_MDU_ZERO_BYPASS_EN
    assign zero_skip = (opa == '0) || (opb == '0);
`else
    assign zero_skip = 1'b0;
`endif

endmodule

// File: rtl/ysyx_22041207_mdu_ctrl.sv
// Execute-stage MUL/MULW controller sitting between the pipeline and a multi-cycle multiplier.
// Optional zero-operand bypass: YSYX_22041207_MDU_ZERO_BYPASS_EN.
//
// state | meaning
// IDLE  | ready for a new request
// ISSUE | offering latched operands to the multiplier
// WAIT  | multiplier running, waiting for its product
// WB    | holding result until writeback accepts it
module ysyx_22041207_mdu_ctrl
    import ysyx_22041207_mdu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [XLEN-1:0]   src1,
    input  logic [XLEN-1:0]   src2,
    input  logic [REG_AW-1:0] rd,
    input  logic              flush,
    output logic              mul_valid,
    output logic              mul_flush,
    output logic [XLEN-1:0]   multiplicand,
    output logic [XLEN-1:0]   multiplier,
    input  logic              mul_ready,
    input  logic              mul_out_valid,
    input  logic [31:0]       mul_hi,
    input  logic [31:0]       mul_lo,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              busy
);

    mdu_state_e        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              wb_valid_q, wb_valid_d;
    logic              mul_flush_q, mul_flush_d;

    logic [XLEN-1:0]   prep_a, prep_b;
    logic              prep_rsvd, prep_zero;
    logic              accept;

    ysyx_22041207_mdu_opprep u_opprep (
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .opa       (prep_a),
        .opb       (prep_b),
        .rsvd      (prep_rsvd),
        .zero_skip (prep_zero)
    );

    assign accept = in_valid && (state_q == ST_IDLE) && !flush;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        wb_data_d   = wb_data_q;
        wb_valid_d  = 1'b0;
        mul_flush_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d     = op;
                    rd_d     = rd;
                    mcand_d  = prep_a;
                    mplier_d = prep_b;
                    // Reserved ops and zero-bypassed products resolve to 0 without the multiplier.
                    if (prep_rsvd || prep_zero) begin
                        state_d    = ST_WB;
                        wb_data_d  = '0;
                        wb_valid_d = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (flush) begin
                    mul_flush_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (mul_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    mul_flush_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (mul_out_valid) begin
                    wb_data_d  = (op_q == MDU_OP_MULW) ? sext32(mul_lo) : {mul_hi, mul_lo};
                    wb_valid_d = 1'b1;
                    state_d    = ST_WB;
                end
            end
            ST_WB: begin
                // flush wins over wb_ready; both leave WB, but only a clean handshake is a writeback.
                if (flush || wb_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    wb_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            wb_data_q   <= '0;
            wb_valid_q  <= 1'b0;
            mul_flush_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            wb_data_q   <= wb_data_d;
            wb_valid_q  <= wb_valid_d;
            mul_flush_q <= mul_flush_d;
        end
    end

    // A request killed this cycle is never offered to the multiplier.
    assign mul_valid    = (state_q == ST_ISSUE) && mul_ready && !flush;
    assign mul_flush    = mul_flush_q;
    assign multiplicand = mcand_q;
    assign multiplier   = mplier_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = rd_q;
    assign wb_data      = wb_data_q;
    assign in_ready     = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ysyx_22041207_mdu_ctrl.sv
// Self-checking bench for ysyx_22041207_mdu_ctrl with a fixed-latency multiplier stand-in.
module tb_ysyx_22041207_mdu_ctrl;

`ifdef YSYX_22041207_MDU_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int MUL_LAT = 33;

    logic        clk, rst;
    logic        in_valid, in_ready, flush;
    logic [1:0]  op;
    logic [63:0] src1, src2;
    logic [4:0]  rd;
    logic        mul_valid, mul_flush, mul_ready, mul_out_valid;
    logic [63:0] multiplicand, multiplier;
    logic [31:0] mul_hi, mul_lo;
    logic        wb_valid, wb_ready, busy;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;

    ysyx_22041207_mdu_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .op            (op),
        .src1          (src1),
        .src2          (src2),
        .rd            (rd),
        .flush         (flush),
        .mul_valid     (mul_valid),
        .mul_flush     (mul_flush),
        .multiplicand  (multiplicand),
        .multiplier    (multiplier),
        .mul_ready     (mul_ready),
        .mul_out_valid (mul_out_valid),
        .mul_hi        (mul_hi),
        .mul_lo        (mul_lo),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stand-in: fixed latency, killed by mul_flush or rst.
    logic        m_busy, m_ov, hold_rdy, stray_ov;
    int          m_cnt;
    logic [63:0] m_prod, stray_val;

    assign mul_ready     = !m_busy && !hold_rdy;
    assign mul_out_valid = m_ov || stray_ov;
    assign mul_hi        = stray_ov ? stray_val[63:32] : m_prod[63:32];
    assign mul_lo        = stray_ov ? stray_val[31:0]  : m_prod[31:0];

    always @(posedge clk) begin
        if (rst || mul_flush) begin
            m_busy <= 1'b0;
            m_ov   <= 1'b0;
            m_cnt  <= 0;
            m_prod <= '0;
        end else begin
            m_ov <= 1'b0;
            if (mul_valid && mul_ready) begin
                m_busy <= 1'b1;
                m_cnt  <= MUL_LAT - 1;
                m_prod <= multiplicand * multiplier;
            end else if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy <= 1'b0;
                    m_ov   <= 1'b1;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    int          n_mul_valid = 0, n_mul_flush = 0, n_wb = 0;
    logic [63:0] last_mc, last_mp;

    always @(posedge clk) begin
        if (mul_valid) begin
            n_mul_valid <= n_mul_valid + 1;
            last_mc     <= multiplicand;
            last_mp     <= multiplier;
        end
        if (mul_flush) n_mul_flush <= n_mul_flush + 1;
        if (wb_valid)  n_wb <= n_wb + 1;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_txn(input logic [1:0] t_op, input logic [63:0] s1, input logic [63:0] s2,
                           input logic [4:0] t_rd, output logic [63:0] d, output logic [4:0] r,
                           output int issues, output int lat);
        int base;
        base     = n_mul_valid;
        in_valid = 1'b1;
        op       = t_op;
        src1     = s1;
        src2     = s2;
        rd       = t_rd;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 0;
        d        = 'x;
        r        = 'x;
        for (int i = 1; i <= 200; i++) begin
            if (wb_valid) begin
                lat = i;
                d   = wb_data;
                r   = wb_rd;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        issues = n_mul_valid - base;
    endtask

    task automatic wait_wb(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (wb_valid) seen = 1'b1;
            else @(negedge clk);
        end
        chk(name, seen, 1);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [63:0] s1, s2;
        logic [4:0]  rd;
        logic [63:0] mc, mp, data;
        int          issues;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [63:0] d;
        logic [4:0]  r;
        int          iss, lat, fb, wbb, mvb;
        bit          seen;

        vecs[0] = '{2'd0, 64'd3, 64'd5, 5'd7, 64'd3, 64'd5, 64'd15, 1, 0};
        vecs[1] = '{2'd1, 64'hFFFFFFFF_80000000, 64'd2, 5'd1,
                    64'hFFFFFFFF_80000000, 64'd2, 64'h0, 1, 0};
        vecs[2] = '{2'd1, 64'h7FFFFFFF, 64'd2, 5'd2, 64'h7FFFFFFF, 64'd2,
                    64'hFFFFFFFF_FFFFFFFE, 1, 0};
        vecs[3] = '{2'd0, 64'hFFFFFFFF_FFFFFFFF, 64'd7, 5'd31, 64'hFFFFFFFF_FFFFFFFF, 64'd7,
                    64'hFFFFFFFF_FFFFFFF9, 1, 0};
        vecs[4] = '{2'd1, 64'h12345678_00000003, 64'hABCDEF00_FFFFFFFF, 5'd5, 64'd3,
                    64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFD, 1, 0};
        vecs[5] = '{2'd0, 64'h1_00000000, 64'h1_00000000, 5'd6, 64'h1_00000000,
                    64'h1_00000000, 64'h0, 1, 0};
        vecs[6] = '{2'd2, 64'd3, 64'd5, 5'd9, 64'd0, 64'd0, 64'h0, 0, 1};
        vecs[7] = '{2'd3, 64'd8, 64'd8, 5'd10, 64'd0, 64'd0, 64'h0, 0, 1};
        vecs[8] = '{2'd0, 64'd9, 64'd0, 5'd11, 64'd9, 64'd0, 64'h0,
                    BYP ? 0 : 1, BYP ? 1 : 0};
        vecs[9] = '{2'd1, 64'hFFFFFFFF_00000000, 64'd5, 5'd12, 64'd0, 64'd5, 64'h0,
                    BYP ? 0 : 1, BYP ? 1 : 0};

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; op = '0; src1 = '0; src2 = '0; rd = '0;
        wb_ready = 1'b1; hold_rdy = 1'b0; stray_ov = 1'b0; stray_val = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mul_valid", mul_valid, 0);
        chk("rst_mul_flush", mul_flush, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_mcand", multiplicand, 0);
        chk("rst_mplier", multiplier, 0);

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].rd, d, r, iss, lat);
            chk($sformatf("v%0d_wb_seen", i), lat > 0, 1);
            chk($sformatf("v%0d_data", i), d, vecs[i].data);
            chk($sformatf("v%0d_rd", i), r, vecs[i].rd);
            chk($sformatf("v%0d_issues", i), iss, vecs[i].issues);
            if (vecs[i].issues != 0) begin
                chk($sformatf("v%0d_mcand", i), last_mc, vecs[i].mc);
                chk($sformatf("v%0d_mplier", i), last_mp, vecs[i].mp);
            end
            if (vecs[i].lat != 0) chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
        end

        // Accept -> mul_valid next cycle; wb_valid the cycle after mul_out_valid.
        in_valid = 1'b1; op = 2'd0; src1 = 64'd3; src2 = 64'd5; rd = 5'd4;
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_mul_valid_n1", mul_valid, 1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (mul_out_valid) begin
                seen = 1'b1;
                chk("lat_wb_before", wb_valid, 0);
                @(negedge clk);
                chk("lat_wb_after", wb_valid, 1);
                chk("lat_wb_data", wb_data, 64'd15);
                chk("lat_wb_rd", wb_rd, 5'd4);
            end
        end
        chk("lat_ov_seen", seen, 1);
        @(negedge clk);

        // ISSUE holds while the multiplier is not ready.
        hold_rdy = 1'b1; mvb = n_mul_valid;
        in_valid = 1'b1; op = 2'd0; src1 = 64'd6; src2 = 64'd7; rd = 5'd3;
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall_mv_0", mul_valid, 0);
        chk("stall_busy", busy, 1);
        @(negedge clk);
        chk("stall_mv_1", mul_valid, 0);
        @(negedge clk);
        hold_rdy = 1'b0;
        #1;
        chk("stall_mv_rel", mul_valid, 1);
        chk("stall_mcand", multiplicand, 64'd6);
        @(negedge clk);
        wait_wb("stall_wb_seen");
        chk("stall_data", wb_data, 64'd42);
        @(negedge clk);
        chk("stall_issues", n_mul_valid - mvb, 1);

        // Flush 10 cycles into WAIT, then a stray mul_out_valid must be ignored.
        fb = n_mul_flush; wbb = n_wb;
        in_valid = 1'b1; op = 2'd0; src1 = 64'd3; src2 = 64'd5; rd = 5'd8;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fw_busy", busy, 0);
        chk("fw_in_ready", in_ready, 1);
        repeat (5) @(negedge clk);
        stray_ov = 1'b1; stray_val = 64'h1234;
        @(negedge clk);
        stray_ov = 1'b0;
        repeat (40) @(negedge clk);
        chk("fw_mul_flush_pulses", n_mul_flush - fb, 1);
        chk("fw_no_wb", n_wb - wbb, 0);
        chk("fw_idle", busy, 0);

        // Flush during ISSUE.
        fb = n_mul_flush; wbb = n_wb;
        in_valid = 1'b1; op = 2'd1; src1 = 64'd3; src2 = 64'd5; rd = 5'd8;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fi_busy", busy, 0);
        repeat (40) @(negedge clk);
        chk("fi_mul_flush_pulses", n_mul_flush - fb, 1);
        chk("fi_no_wb", n_wb - wbb, 0);

        // Flush in IDLE blocks acceptance and does not touch the multiplier.
        fb = n_mul_flush;
        in_valid = 1'b1; flush = 1'b1; op = 2'd0; src1 = 64'd3; src2 = 64'd5;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("fid_busy", busy, 0);
        chk("fid_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        chk("fid_no_mul_flush", n_mul_flush - fb, 0);

        // WB back-pressure: result held stable, no new acceptance.
        wb_ready = 1'b0;
        in_valid = 1'b1; op = 2'd1; src1 = 64'h7FFFFFFF; src2 = 64'd2; rd = 5'd12;
        @(negedge clk);
        in_valid = 1'b0;
        wait_wb("bp_wb_seen");
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; op = 2'd0; src1 = 64'd1; src2 = 64'd1; rd = 5'd1;
            chk($sformatf("bp_valid_%0d", i), wb_valid, 1);
            chk($sformatf("bp_data_%0d", i), wb_data, 64'hFFFFFFFF_FFFFFFFE);
            chk($sformatf("bp_rd_%0d", i), wb_rd, 5'd12);
            chk($sformatf("bp_in_ready_%0d", i), in_ready, 0);
            @(negedge clk);
        end
        in_valid = 1'b0; wb_ready = 1'b1;
        @(negedge clk);
        chk("bp_done_valid", wb_valid, 0);
        chk("bp_done_idle", in_ready, 1);

        // flush and wb_ready together in WB: flush wins, back to IDLE.
        wb_ready = 1'b0;
        in_valid = 1'b1; op = 2'd2; src1 = 64'd1; src2 = 64'd1; rd = 5'd13;
        @(negedge clk);
        in_valid = 1'b0;
        chk("fwb_valid_pre", wb_valid, 1);
        flush = 1'b1; wb_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fwb_valid_post", wb_valid, 0);
        chk("fwb_idle", in_ready, 1);

        // Reset mid-operation abandons the request.
        wbb = n_wb;
        in_valid = 1'b1; op = 2'd0; src1 = 64'd3; src2 = 64'd5; rd = 5'd14;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1; flush = 1'b1;
        @(negedge clk);
        rst = 1'b0; flush = 1'b0;
        chk("rmid_busy", busy, 0);
        chk("rmid_mcand", multiplicand, 0);
        chk("rmid_mplier", multiplier, 0);
        chk("rmid_wb_data", wb_data, 0);
        chk("rmid_wb_rd", wb_rd, 0);
        chk("rmid_mul_flush", mul_flush, 0);
        repeat (50) @(negedge clk);
        chk("rmid_no_wb", n_wb - wbb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
